// File: rtl/lms_train_source_if.sv
// Handshake/data bundle between the LMS training source and the block that
// controls it and feeds back the filter output.
interface lms_train_source_if;
  logic               start;
  logic               abort;
  logic signed [15:0] h0;
  logic signed [15:0] h1;
  logic signed [15:0] y_in;
  logic signed [15:0] x_out;
  logic signed [15:0] d_out;
  logic               busy;
  logic               converged;
  logic               timed_out;
  logic [16:0]        err_abs;
  logic [12:0]        sample_cnt;

  modport master (
    output start, abort, h0, h1, y_in,
    input  x_out, d_out, busy, converged, timed_out, err_abs, sample_cnt
  );

  modport slave (
    input  start, abort, h0, h1, y_in,
    output x_out, d_out, busy, converged, timed_out, err_abs, sample_cnt
  );
endinterface

// File: rtl/lms_train_source.sv
// PRBS training source for a 2-tap LMS filter: drives x/d through a programmable
// channel, checks the returned y against the aligned reference, flags pass/timeout.
module lms_train_source #(
  parameter int          AMP         = 4,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          D_DELAY     = 1,
  parameter int          Y_LAT       = 2,
  parameter int          TOL         = 2,
  parameter int          CONV_RUN    = 16,
  parameter int          MAX_SAMPLES = 4096
) (
  input logic               clk,
  input logic               rst,
  lms_train_source_if.slave bus
);
  localparam int PRIME_LEN = Y_LAT + D_DELAY;
  localparam int LINE_LEN  = (Y_LAT > D_DELAY) ? Y_LAT : D_DELAY;
  localparam int PW        = $clog2(PRIME_LEN + 1);
  localparam int RW        = $clog2(CONV_RUN + 1);

  localparam logic signed [15:0] AMP_P      = 16'(AMP);
  localparam logic signed [15:0] AMP_N      = 16'(-AMP);
  localparam logic [12:0]        CNT_MAX    = 13'(MAX_SAMPLES);
  localparam logic [RW-1:0]      RUN_DONE   = RW'(CONV_RUN);
  localparam logic [16:0]        TOL_V      = 17'(TOL);
  localparam logic [PW-1:0]      PRIME_LAST = PW'(PRIME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    TRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic signed [15:0] amp_of(input logic b);
    return b ? AMP_P : AMP_N;
  endfunction

  state_t             state_r, state_case_s, state_next_s;
  logic [15:0]        lfsr_r;
  logic signed [15:0] h0_r, h1_r, x_out_r, x_prev_r;
  logic signed [15:0] line_r [LINE_LEN];
  logic [PW-1:0]      prime_r;
  logic [RW-1:0]      run_r, run_next_s;
  logic [12:0]        cnt_r, cnt_next_s;
  logic [16:0]        err_abs_r, abs_s;
  logic               busy_r, conv_r, tout_r;
  logic signed [15:0] dref_s, ref_s;
  logic signed [16:0] e_s;
  logic               load_s, stream_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_case_s = state_r;
    case (state_r)
      IDLE:  if (bus.start) state_case_s = PRIME; else state_case_s = IDLE;
      PRIME: if (prime_r == PRIME_LAST) state_case_s = TRAIN; else state_case_s = PRIME;
      TRAIN: begin
        if (run_next_s == RUN_DONE) state_case_s = PASS;
        else if (cnt_next_s == CNT_MAX) state_case_s = FAIL;
        else state_case_s = TRAIN;
      end
      PASS, FAIL: if (bus.start) state_case_s = PRIME; else state_case_s = state_r;
      default: state_case_s = IDLE;
    endcase
    if (bus.abort) state_next_s = IDLE;
    else state_next_s = state_case_s;
    load_s   = (state_next_s == PRIME) && (state_r != PRIME);
    stream_s = (state_next_s == PRIME) || (state_next_s == TRAIN);
  end

  // Channel reference and residual; a 16-bit result keeps exactly the low
  // half of the 32-bit product sum, i.e. the filter's wrap behaviour.
  always_comb begin
    dref_s = h0_r * x_out_r + h1_r * x_prev_r;
    ref_s  = line_r[Y_LAT-1];
    e_s    = {ref_s[15], ref_s} - {bus.y_in[15], bus.y_in};
    abs_s  = e_s[16] ? (~e_s + 17'd1) : e_s;
    if (abs_s <= TOL_V) run_next_s = run_r + RW'(1);
    else run_next_s = '0;
    if (cnt_r == CNT_MAX) cnt_next_s = cnt_r;
    else cnt_next_s = cnt_r + 13'd1;
  end

  // Excitation, reference delay line, monitor counters and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r    <= SEED;
      h0_r      <= 16'sd0;
      h1_r      <= 16'sd0;
      x_out_r   <= 16'sd0;
      x_prev_r  <= 16'sd0;
      for (int i = 0; i < LINE_LEN; i++) line_r[i] <= 16'sd0;
      prime_r   <= '0;
      run_r     <= '0;
      cnt_r     <= 13'd0;
      err_abs_r <= 17'd0;
      busy_r    <= 1'b0;
      conv_r    <= 1'b0;
      tout_r    <= 1'b0;
    end else begin
      busy_r <= stream_s;
      conv_r <= (state_next_s == PASS);
      tout_r <= (state_next_s == FAIL);
      if (load_s) begin
        h0_r     <= bus.h0;
        h1_r     <= bus.h1;
        lfsr_r   <= lfsr_step(SEED);
        x_out_r  <= amp_of(SEED[0]);
        x_prev_r <= 16'sd0;
        for (int i = 0; i < LINE_LEN; i++) line_r[i] <= 16'sd0;
        prime_r  <= '0;
      end else if (stream_s) begin
        lfsr_r    <= lfsr_step(lfsr_r);
        x_out_r   <= amp_of(lfsr_r[0]);
        x_prev_r  <= x_out_r;
        line_r[0] <= dref_s;
        for (int i = 1; i < LINE_LEN; i++) line_r[i] <= line_r[i-1];
        if (state_r == PRIME) prime_r <= prime_r + PW'(1);
        else prime_r <= prime_r;
      end else begin
        lfsr_r   <= SEED;
        x_out_r  <= 16'sd0;
        x_prev_r <= 16'sd0;
        for (int i = 0; i < LINE_LEN; i++) line_r[i] <= 16'sd0;
        prime_r  <= '0;
      end
      if (load_s || bus.abort) begin
        run_r     <= '0;
        cnt_r     <= 13'd0;
        err_abs_r <= 17'd0;
      end else if (state_r == TRAIN) begin
        run_r     <= run_next_s;
        cnt_r     <= cnt_next_s;
        err_abs_r <= abs_s;
      end else begin
        run_r     <= run_r;
        cnt_r     <= cnt_r;
        err_abs_r <= err_abs_r;
      end
    end
  end

  assign bus.x_out      = x_out_r;
  assign bus.d_out      = line_r[D_DELAY-1];
  assign bus.busy       = busy_r;
  assign bus.converged  = conv_r;
  assign bus.timed_out  = tout_r;
  assign bus.err_abs    = err_abs_r;
  assign bus.sample_cnt = cnt_r;
endmodule

// File: tb/tb_lms_train_source.sv
// Bench for lms_train_source: table of training runs (fixed corner cases plus
// random channels/residual noise) checked cycle by cycle against a sample model.
module tb_lms_train_source;
  localparam int AMP  = 4;
  localparam int D    = 1;
  localparam int Y    = 2;
  localparam int TOL  = 2;
  localparam int CONV = 16;
  localparam int MAXS = 4096;
  localparam int P    = Y + D;
  localparam int SEED = 32'h0000ACE1;
  localparam int NCYC = P + MAXS + 8;

  localparam int M_CONST  = 0;
  localparam int M_STUCK  = 1;
  localparam int M_GLITCH = 2;
  localparam int M_RAND   = 3;
  localparam int M_ABORT  = 4;
  localparam int NFIX     = 8;
  localparam int NROWS    = 14;

  typedef struct {
    int h0;
    int h1;
    int mode;
    int off;
    int abort_at;
    int exp_pass;
    int exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   xs [NCYC];
  int   dr [NCYC];
  vec_t tbl [NROWS];

  lms_train_source_if bus ();

  lms_train_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s cycle=%0d got=%0d expected=%0d", tag, name, k, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int s16(input int v);
    int t;
    t = v & 32'h0000FFFF;
    if (t >= 32768) t -= 65536;
    return t;
  endfunction

  function automatic int lfsr_next(input int s);
    int fb;
    fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return (s >> 1) | (fb << 15);
  endfunction

  task automatic chk_idle(input string tag, input int k, input int conv, input int tout,
                          input int eabs, input int cnt);
    chk(tag, "busy", k, int'(bus.busy), 0);
    chk(tag, "x_out", k, int'(bus.x_out), 0);
    chk(tag, "d_out", k, int'(bus.d_out), 0);
    chk(tag, "converged", k, int'(bus.converged), conv);
    chk(tag, "timed_out", k, int'(bus.timed_out), tout);
    chk(tag, "err_abs", k, int'(bus.err_abs), eabs);
    chk(tag, "sample_cnt", k, int'(bus.sample_cnt), cnt);
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
  endtask

  // One full training run: model the sample stream, drive y_in, compare each cycle.
  task automatic do_run(input vec_t v, input string tag);
    int s, run, cnt, last_abs, y, e, f0;
    bit ended, passed, aborted;
    s = SEED;
    for (int k = 0; k < NCYC; k++) begin
      xs[k] = (s & 1) ? AMP : -AMP;
      s = lfsr_next(s);
      dr[k] = s16(v.h0 * xs[k] + ((k > 0) ? v.h1 * xs[k-1] : 0));
    end
    bus.h0 = 16'(v.h0);
    bus.h1 = 16'(v.h1);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.h0 = 16'($urandom);
    bus.h1 = 16'($urandom);
    run = 0; cnt = 0; last_abs = 0;
    ended = 1'b0; passed = 1'b0; aborted = 1'b0;
    f0 = failures;
    for (int k = 0; k < NCYC && !ended && !aborted && failures == f0; k++) begin
      chk(tag, "busy", k, int'(bus.busy), 1);
      chk(tag, "x_out", k, int'(bus.x_out), xs[k]);
      chk(tag, "d_out", k, int'(bus.d_out), (k >= D) ? dr[k-D] : 0);
      chk(tag, "err_abs", k, int'(bus.err_abs), last_abs);
      chk(tag, "sample_cnt", k, int'(bus.sample_cnt), cnt);
      chk(tag, "converged", k, int'(bus.converged), 0);
      chk(tag, "timed_out", k, int'(bus.timed_out), 0);
      if (k < P) y = s16(int'($urandom));
      else if (v.mode == M_STUCK) y = 0;
      else if (v.mode == M_GLITCH) y = s16(dr[k-Y] + (((k - P) == v.off) ? 3 : 0));
      else if (v.mode == M_RAND)
        y = s16(dr[k-Y] + (($urandom_range(15) == 0) ? int'($urandom_range(100)) - 50
                                                       : int'($urandom_range(4)) - 2));
      else y = s16(dr[k-Y] + v.off);
      bus.y_in = 16'(y);
      if (k == v.abort_at) begin
        pulse_abort();
        chk_idle(tag, k + 1, 0, 0, 0, 0);
        aborted = 1'b1;
      end else begin
        if (k >= P) begin
          e = dr[k-Y] - y;
          last_abs = (e < 0) ? -e : e;
          run = (last_abs <= TOL) ? run + 1 : 0;
          if (cnt < MAXS) cnt++;
          if (run == CONV) begin
            ended = 1'b1;
            passed = 1'b1;
          end else if (cnt == MAXS) begin
            ended = 1'b1;
          end
        end
        cycle();
      end
    end
    if (failures != f0) begin
      pulse_abort();
    end else if (!aborted) begin
      chk(tag, "run_ended", 0, int'(ended), 1);
      chk_idle(tag, 0, int'(passed), int'(!passed), last_abs, cnt);
      if (v.exp_cnt > 0) begin
        chk(tag, "table_pass", 0, int'(bus.converged), v.exp_pass);
        chk(tag, "table_cnt", 0, int'(bus.sample_cnt), v.exp_cnt);
      end
      cycle();
      chk(tag, "sticky_conv", 1, int'(bus.converged), int'(passed));
      chk(tag, "sticky_tout", 1, int'(bus.timed_out), int'(!passed));
    end
  endtask

  initial begin
    int exp_x [3];
    int exp_d [4];
    exp_x[0] = 4;  exp_x[1] = -4;  exp_x[2] = -4;
    exp_d[0] = 0;  exp_d[1] = 12;  exp_d[2] = -12; exp_d[3] = -12;

    //            h0  h1  mode      off abort  pass cnt
    tbl[0] = '{   3,  0, M_CONST,   0,  -1,    1,   16};
    tbl[1] = '{   5,  0, M_STUCK,   0,  -1,    0, 4096};
    tbl[2] = '{   7, -2, M_CONST,   2,  -1,    1,   16};
    tbl[3] = '{   7, -2, M_CONST,  -2,  -1,    1,   16};
    tbl[4] = '{   3,  1, M_CONST,   3,  -1,    0, 4096};
    tbl[5] = '{  -9,  4, M_GLITCH,  9,  -1,    1,   26};
    tbl[6] = '{   3,  0, M_ABORT,   0, P+5,    0,    0};
    tbl[7] = '{   1,  1, M_CONST,   0,  -1,    1,   16};
    for (int i = NFIX; i < NROWS; i++)
      tbl[i] = '{s16(int'($urandom)), s16(int'($urandom)), M_RAND, 0, -1, 0, 0};

    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.h0 = 16'sd3;
    bus.h1 = 16'sd0;
    bus.y_in = 16'sd0;
    rst = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    cycle();
    chk_idle("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle();
    cycle();
    chk_idle("idle", 0, 0, 0, 0, 0);

    // Hand sequence: first excitation samples and one-cycle-late desired signal.
    bus.h0 = 16'sd3;
    bus.h1 = 16'sd0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) chk("seq", "x_out", k, int'(bus.x_out), exp_x[k]);
      chk("seq", "d_out", k, int'(bus.d_out), exp_d[k]);
      cycle();
    end
    pulse_abort();
    chk_idle("seq_abort", 0, 0, 0, 0, 0);

    for (int i = 0; i < NROWS; i++) do_run(tbl[i], $sformatf("row%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
